// File: rtl/span_writer.sv
// Span rasteriser and line clearer feeding the double-buffered line store.
// Optional feature macro: SPAN_CLIP_EN clamps span ends to LINE_WIDTH.
module span_writer #(
    parameter int unsigned LINE_WIDTH   = 640,
    parameter logic [8:0]  CLEAR_COLOUR = 9'h000
) (
    input  logic        clk_draw,
    input  logic        rst_draw,
    input  logic        line_start,
    input  logic        span_valid,
    output logic        span_ready,
    input  logic [11:0] span_x,
    input  logic [11:0] span_len,
    input  logic [8:0]  span_colour,
    output logic        span_busy,
    output logic        clear_busy,
    output logic [8:0]  addr_on_draw,
    output logic        we_on_draw,
    output logic [71:0] colour_on_draw,
    output logic [8:0]  addr_off_draw,
    output logic [7:0]  we_off_draw,
    output logic [71:0] colour_off_draw
);

    localparam logic [8:0] LastClrAddr = 9'(LINE_WIDTH / 8 - 1);
`ifdef SPAN_CLIP_EN
    localparam logic [12:0] LineEnd = 13'(LINE_WIDTH);
`endif

    typedef enum logic {StIdle, StRun} span_state_e;

    span_state_e state_q;
    logic [12:0] cur_x_q;
    logic [12:0] end_x_q;
    logic [8:0]  colour_q;

    logic        accept;
    logic [12:0] sum;
    logic [12:0] acc_end;
    logic        more;
    logic        src_ok;
    logic [11:0] src_x;
    logic [12:0] src_end;
    logic [8:0]  src_col;
    logic [8:0]  word;
    logic [12:0] base;
    logic [12:0] next_x;
    logic        last;
    logic [7:0]  mask;

    assign accept = span_valid && span_ready;
    assign sum    = {1'b0, span_x} + {1'b0, span_len};
    assign more   = (state_q == StRun) && (cur_x_q < end_x_q) && !line_start;

    always_comb begin
        acc_end = (sum > 13'd4096) ? 13'd4096 : sum;
`ifdef SPAN_CLIP_EN
        if (acc_end > LineEnd) acc_end = LineEnd;
`endif
    end

    // Select the word to emit next: a freshly accepted command wins over continuation.
    always_comb begin
        src_ok  = 1'b0;
        src_x   = 12'd0;
        src_end = 13'd0;
        src_col = 9'd0;
        if (accept) begin
            src_x   = span_x;
            src_end = acc_end;
            src_col = span_colour;
            src_ok  = acc_end > {1'b0, span_x};
        end else if (more) begin
            src_x   = cur_x_q[11:0];
            src_end = end_x_q;
            src_col = colour_q;
            src_ok  = 1'b1;
        end
    end

    always_comb begin
        word   = src_x[11:3];
        base   = {1'b0, word, 3'b000};
        next_x = base + 13'd8;
        last   = next_x >= src_end;
        mask   = 8'd0;
        for (int i = 0; i < 8; i++) begin
            mask[i] = ((base + 13'(i)) >= {1'b0, src_x}) && ((base + 13'(i)) < src_end);
        end
    end

    always_ff @(posedge clk_draw) begin
        if (rst_draw) begin
            state_q         <= StIdle;
            cur_x_q         <= 13'd0;
            end_x_q         <= 13'd0;
            colour_q        <= 9'd0;
            span_ready      <= 1'b0;
            addr_off_draw   <= 9'd0;
            we_off_draw     <= 8'd0;
            colour_off_draw <= 72'd0;
        end else if (src_ok) begin
            state_q         <= StRun;
            cur_x_q         <= next_x;
            end_x_q         <= src_end;
            colour_q        <= src_col;
            span_ready      <= last;
            addr_off_draw   <= word;
            we_off_draw     <= mask;
            colour_off_draw <= {8{src_col}};
        end else begin
            state_q     <= StIdle;
            span_ready  <= 1'b1;
            we_off_draw <= 8'd0;
        end
    end

    assign span_busy = (state_q == StRun);

    always_ff @(posedge clk_draw) begin
        if (rst_draw) begin
            we_on_draw   <= 1'b0;
            addr_on_draw <= 9'd0;
        end else if (line_start) begin
            we_on_draw   <= 1'b1;
            addr_on_draw <= 9'd0;
        end else if (we_on_draw) begin
            if (addr_on_draw == LastClrAddr) begin
                we_on_draw <= 1'b0;
            end else begin
                addr_on_draw <= addr_on_draw + 9'd1;
            end
        end
    end

    assign clear_busy     = we_on_draw;
    assign colour_on_draw = {8{CLEAR_COLOUR}};

endmodule

// File: tb/tb_span_writer.sv
// Directed testbench for span_writer with LINE_WIDTH = 640; honours SPAN_CLIP_EN.
module tb_span_writer;

    logic        clk_draw = 1'b0;
    logic        rst_draw;
    logic        line_start;
    logic        span_valid;
    logic        span_ready;
    logic [11:0] span_x;
    logic [11:0] span_len;
    logic [8:0]  span_colour;
    logic        span_busy;
    logic        clear_busy;
    logic [8:0]  addr_on_draw;
    logic        we_on_draw;
    logic [71:0] colour_on_draw;
    logic [8:0]  addr_off_draw;
    logic [7:0]  we_off_draw;
    logic [71:0] colour_off_draw;

    int n_cmp  = 0;
    int n_fail = 0;

    span_writer #(
        .LINE_WIDTH  (640),
        .CLEAR_COLOUR(9'h000)
    ) dut (
        .clk_draw       (clk_draw),
        .rst_draw       (rst_draw),
        .line_start     (line_start),
        .span_valid     (span_valid),
        .span_ready     (span_ready),
        .span_x         (span_x),
        .span_len       (span_len),
        .span_colour    (span_colour),
        .span_busy      (span_busy),
        .clear_busy     (clear_busy),
        .addr_on_draw   (addr_on_draw),
        .we_on_draw     (we_on_draw),
        .colour_on_draw (colour_on_draw),
        .addr_off_draw  (addr_off_draw),
        .we_off_draw    (we_off_draw),
        .colour_off_draw(colour_off_draw)
    );

    always #5 clk_draw = ~clk_draw;

    // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
    task automatic step();
        @(posedge clk_draw);
        #1;
    endtask

    task automatic test_reset();
        rst_draw = 1'b1; line_start = 1'b0; span_valid = 1'b0;
        span_x = 12'd0; span_len = 12'd0; span_colour = 9'd0;
        step(); step();
        n_cmp++; if (span_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready got %b want 0", span_ready); end
        n_cmp++; if (we_off_draw !== 8'h00) begin n_fail++; $display("FAIL reset_we_off got %h want 00", we_off_draw); end
        n_cmp++; if (we_on_draw !== 1'b0 || clear_busy !== 1'b0) begin n_fail++; $display("FAIL reset_clear got we=%b busy=%b want 0/0", we_on_draw, clear_busy); end
        n_cmp++; if (span_busy !== 1'b0) begin n_fail++; $display("FAIL reset_span_busy got %b want 0", span_busy); end
        n_cmp++; if (addr_on_draw !== 9'd0 || addr_off_draw !== 9'd0) begin n_fail++; $display("FAIL reset_addr got on=%0d off=%0d want 0/0", addr_on_draw, addr_off_draw); end
        n_cmp++; if (colour_off_draw !== 72'd0) begin n_fail++; $display("FAIL reset_colour got %h want 0", colour_off_draw); end
        rst_draw = 1'b0;
        step();
        n_cmp++; if (span_ready !== 1'b1) begin n_fail++; $display("FAIL ready_after_reset got %b want 1", span_ready); end
    endtask

    task automatic test_unaligned();
        span_x = 12'd3; span_len = 12'd10; span_colour = 9'h1A5; span_valid = 1'b1;
        step();
        span_valid = 1'b0;
        n_cmp++; if (addr_off_draw !== 9'd0 || we_off_draw !== 8'b1111_1000) begin n_fail++; $display("FAIL unaligned_w0 got addr=%0d we=%b want 0/11111000", addr_off_draw, we_off_draw); end
        n_cmp++; if (colour_off_draw !== {8{9'h1A5}}) begin n_fail++; $display("FAIL unaligned_colour got %h want %h", colour_off_draw, {8{9'h1A5}}); end
        n_cmp++; if (span_busy !== 1'b1) begin n_fail++; $display("FAIL unaligned_busy got %b want 1", span_busy); end
        step();
        n_cmp++; if (addr_off_draw !== 9'd1 || we_off_draw !== 8'b0001_1111) begin n_fail++; $display("FAIL unaligned_w1 got addr=%0d we=%b want 1/00011111", addr_off_draw, we_off_draw); end
        step();
        n_cmp++; if (we_off_draw !== 8'h00 || span_busy !== 1'b0) begin n_fail++; $display("FAIL unaligned_done got we=%h busy=%b want 00/0", we_off_draw, span_busy); end
    endtask

    task automatic test_back_to_back();
        span_x = 12'd16; span_len = 12'd16; span_colour = 9'h0F0; span_valid = 1'b1;
        step();
        span_x = 12'd40; span_len = 12'd1;
        n_cmp++; if (addr_off_draw !== 9'd2 || we_off_draw !== 8'hFF) begin n_fail++; $display("FAIL b2b_a2 got addr=%0d we=%h want 2/FF", addr_off_draw, we_off_draw); end
        n_cmp++; if (span_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_ready_mid got %b want 0", span_ready); end
        step();
        n_cmp++; if (addr_off_draw !== 9'd3 || we_off_draw !== 8'hFF) begin n_fail++; $display("FAIL b2b_a3 got addr=%0d we=%h want 3/FF", addr_off_draw, we_off_draw); end
        n_cmp++; if (span_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_last got %b want 1", span_ready); end
        step();
        span_valid = 1'b0;
        n_cmp++; if (addr_off_draw !== 9'd5 || we_off_draw !== 8'b0000_0001) begin n_fail++; $display("FAIL b2b_a5 got addr=%0d we=%b want 5/00000001", addr_off_draw, we_off_draw); end
        step();
        n_cmp++; if (we_off_draw !== 8'h00) begin n_fail++; $display("FAIL b2b_done got we=%h want 00", we_off_draw); end
    endtask

    task automatic test_clear();
        line_start = 1'b1;
        span_x = 12'd0; span_len = 12'd8; span_colour = 9'h155; span_valid = 1'b1;
        step();
        line_start = 1'b0; span_valid = 1'b0;
        n_cmp++; if (addr_off_draw !== 9'd0 || we_off_draw !== 8'hFF) begin n_fail++; $display("FAIL clear_span got addr=%0d we=%h want 0/FF", addr_off_draw, we_off_draw); end
        for (int i = 0; i < 80; i++) begin
            n_cmp++;
            if (we_on_draw !== 1'b1 || clear_busy !== 1'b1 || addr_on_draw !== 9'(i)) begin
                n_fail++;
                $display("FAIL clear_word got we=%b busy=%b addr=%0d want 1/1/%0d", we_on_draw, clear_busy, addr_on_draw, i);
            end
            n_cmp++; if (colour_on_draw !== 72'd0) begin n_fail++; $display("FAIL clear_colour got %h want 0", colour_on_draw); end
            if (i == 1) begin
                n_cmp++; if (we_off_draw !== 8'h00) begin n_fail++; $display("FAIL clear_span_end got we=%h want 00", we_off_draw); end
            end
            step();
        end
        n_cmp++; if (we_on_draw !== 1'b0 || clear_busy !== 1'b0) begin n_fail++; $display("FAIL clear_end got we=%b busy=%b want 0/0", we_on_draw, clear_busy); end
    endtask

    task automatic test_clip();
        span_x = 12'd636; span_len = 12'd20; span_colour = 9'h033; span_valid = 1'b1;
        step();
        span_valid = 1'b0;
        n_cmp++; if (addr_off_draw !== 9'd79 || we_off_draw !== 8'hF0) begin n_fail++; $display("FAIL clip_a79 got addr=%0d we=%h want 79/F0", addr_off_draw, we_off_draw); end
`ifdef SPAN_CLIP_EN
        n_cmp++; if (span_ready !== 1'b1) begin n_fail++; $display("FAIL clip_last got ready=%b want 1", span_ready); end
`else
        step();
        n_cmp++; if (addr_off_draw !== 9'd80 || we_off_draw !== 8'hFF) begin n_fail++; $display("FAIL noclip_a80 got addr=%0d we=%h want 80/FF", addr_off_draw, we_off_draw); end
        step();
        n_cmp++; if (addr_off_draw !== 9'd81 || we_off_draw !== 8'hFF) begin n_fail++; $display("FAIL noclip_a81 got addr=%0d we=%h want 81/FF", addr_off_draw, we_off_draw); end
`endif
        step();
        n_cmp++; if (we_off_draw !== 8'h00 || span_busy !== 1'b0) begin n_fail++; $display("FAIL clip_done got we=%h busy=%b want 00/0", we_off_draw, span_busy); end
    endtask

    task automatic test_degenerate();
        span_x = 12'd5; span_len = 12'd0; span_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            n_cmp++;
            if (we_off_draw !== 8'h00 || span_ready !== 1'b1 || span_busy !== 1'b0) begin
                n_fail++;
                $display("FAIL len0 got we=%h ready=%b busy=%b want 00/1/0", we_off_draw, span_ready, span_busy);
            end
        end
        span_x = 12'd700; span_len = 12'd10;
        step();
        span_valid = 1'b0;
`ifdef SPAN_CLIP_EN
        n_cmp++; if (we_off_draw !== 8'h00 || span_ready !== 1'b1) begin n_fail++; $display("FAIL x700_drop got we=%h ready=%b want 00/1", we_off_draw, span_ready); end
`else
        n_cmp++; if (addr_off_draw !== 9'd87 || we_off_draw !== 8'hF0) begin n_fail++; $display("FAIL x700_a87 got addr=%0d we=%h want 87/F0", addr_off_draw, we_off_draw); end
        step();
        n_cmp++; if (addr_off_draw !== 9'd88 || we_off_draw !== 8'h3F) begin n_fail++; $display("FAIL x700_a88 got addr=%0d we=%h want 88/3F", addr_off_draw, we_off_draw); end
`endif
        step();
        n_cmp++; if (we_off_draw !== 8'h00) begin n_fail++; $display("FAIL x700_done got we=%h want 00", we_off_draw); end
    endtask

    task automatic test_abort();
        span_x = 12'd0; span_len = 12'd32; span_colour = 9'h0AA; span_valid = 1'b1;
        step();
        span_valid = 1'b0;
        n_cmp++; if (addr_off_draw !== 9'd0 || we_off_draw !== 8'hFF) begin n_fail++; $display("FAIL abort_w0 got addr=%0d we=%h want 0/FF", addr_off_draw, we_off_draw); end
        step();
        n_cmp++; if (addr_off_draw !== 9'd1 || we_off_draw !== 8'hFF) begin n_fail++; $display("FAIL abort_w1 got addr=%0d we=%h want 1/FF", addr_off_draw, we_off_draw); end
        line_start = 1'b1;
        step();
        line_start = 1'b0;
        n_cmp++; if (we_off_draw !== 8'h00 || span_busy !== 1'b0) begin n_fail++; $display("FAIL abort_stop got we=%h busy=%b want 00/0", we_off_draw, span_busy); end
        n_cmp++; if (we_on_draw !== 1'b1 || addr_on_draw !== 9'd0) begin n_fail++; $display("FAIL abort_clear got we=%b addr=%0d want 1/0", we_on_draw, addr_on_draw); end
        step();
        n_cmp++; if (we_off_draw !== 8'h00) begin n_fail++; $display("FAIL abort_quiet got we=%h want 00", we_off_draw); end
        step(); step();
        rst_draw = 1'b1;
        step();
        n_cmp++; if (we_on_draw !== 1'b0 || clear_busy !== 1'b0) begin n_fail++; $display("FAIL rst_sweep got we=%b busy=%b want 0/0", we_on_draw, clear_busy); end
        n_cmp++; if (span_ready !== 1'b0 || addr_on_draw !== 9'd0) begin n_fail++; $display("FAIL rst_outputs got ready=%b addr=%0d want 0/0", span_ready, addr_on_draw); end
        rst_draw = 1'b0;
        step();
        n_cmp++; if (span_ready !== 1'b1 || we_on_draw !== 1'b0) begin n_fail++; $display("FAIL rst_release got ready=%b we=%b want 1/0", span_ready, we_on_draw); end
    endtask

    initial begin
        test_reset();
        test_unaligned();
        test_back_to_back();
        test_clear();
        test_clip();
        test_degenerate();
        test_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
